// File: rtl/rvfi_step_scheduler.sv
// In-order scheduler that steps the ISS once per retired RVFI instruction and checks its pc/insn.
// Define RVFI_STEP_SCHED_TIMEOUT_EN to add the step watchdog and the timeout_o port.
module rvfi_step_scheduler #(
  parameter int NRET    = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NRET-1:0]      rvfi_valid_i,
  input  logic [NRET*64-1:0]   rvfi_order_i,
  input  logic [NRET*XLEN-1:0] rvfi_pc_i,
  input  logic [NRET*ILEN-1:0] rvfi_insn_i,
  output logic                 step_valid_o,
  input  logic                 step_ready_i,
  output logic [63:0]          step_order_o,
  input  logic                 rslt_valid_i,
  input  logic [XLEN-1:0]      rslt_pc_i,
  input  logic [ILEN-1:0]      rslt_insn_i,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 mismatch_o,
  output logic                 order_err_o,
  output logic                 overflow_o,
  output logic [31:0]          steps_o
`ifdef RVFI_STEP_SCHED_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE: queue empty | ISSUE: request offered | WAIT: awaiting ISS result | HALT: error seen, absorbing
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_e;
  state_e state_q, state_d;

  logic [63:0]     ord_mem_q  [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [ILEN-1:0] insn_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [63:0]   exp_q, exp_d;
  logic          mis_q, mis_d, oerr_q, oerr_d, ovf_q, ovf_d;
  logic [31:0]   steps_q, steps_d;

  logic [CW-1:0] n_valid, occ_pop, free_cnt;
  logic [PW-1:0] lane_slot [NRET];
  logic          lower_ok, gap, ord_bad, pop, push, no_room, ovf_set, mis_set, tmo_set;

  always_comb begin
    n_valid  = '0;
    lower_ok = 1'b1;
    gap      = 1'b0;
    ord_bad  = 1'b0;
    exp_d    = exp_q;
    for (int l = 0; l < NRET; l++) begin
      lane_slot[l] = wr_ptr_q + n_valid[PW-1:0];
      if (rvfi_valid_i[l]) begin
        if (!lower_ok) gap = 1'b1;
        if (rvfi_order_i[l*64 +: 64] != exp_d) ord_bad = 1'b1;
        exp_d   = rvfi_order_i[l*64 +: 64] + 64'd1;
        n_valid = n_valid + CW'(1);
      end
      lower_ok = lower_ok & rvfi_valid_i[l];
    end

    // Room is judged after a same-cycle pop so a full-1 queue can take a pop plus a 2-lane push.
    pop      = (state_q == WAIT) && rslt_valid_i;
    occ_pop  = occ_q - CW'(pop);
    free_cnt = CW'(DEPTH) - occ_pop;
    no_room  = n_valid > free_cnt;
    push     = (n_valid != '0) && !no_room;
    ovf_set  = no_room && (state_q != HALT);
    if (!push) begin
      exp_d   = exp_q;
      gap     = 1'b0;
      ord_bad = 1'b0;
    end
    wr_ptr_d = push ? wr_ptr_q + n_valid[PW-1:0] : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    occ_d    = push ? occ_pop + n_valid : occ_pop;
  end

  assign mis_set = pop && ((rslt_pc_i != pc_mem_q[rd_ptr_q]) ||
                           (rslt_insn_i != insn_mem_q[rd_ptr_q]));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (occ_d != '0) state_d = ISSUE;
      ISSUE:   if (step_ready_i) state_d = WAIT;
      WAIT:    if (rslt_valid_i) state_d = (occ_d != '0) ? ISSUE : IDLE;
      default: state_d = HALT;
    endcase
    if (gap || ord_bad || ovf_set || mis_set || tmo_set) state_d = HALT;
  end

  assign mis_d   = mis_q | mis_set;
  assign oerr_d  = oerr_q | gap | ord_bad;
  assign ovf_d   = ovf_q | ovf_set;
  assign steps_d = (pop && (steps_q != '1)) ? steps_q + 32'd1 : steps_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      exp_q    <= '0;
      mis_q    <= 1'b0;
      oerr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      exp_q    <= exp_d;
      mis_q    <= mis_d;
      oerr_q   <= oerr_d;
      ovf_q    <= ovf_d;
      steps_q  <= steps_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int l = 0; l < NRET; l++) begin
        if (rvfi_valid_i[l]) begin
          ord_mem_q[lane_slot[l]]  <= rvfi_order_i[l*64 +: 64];
          pc_mem_q[lane_slot[l]]   <= rvfi_pc_i[l*XLEN +: XLEN];
          insn_mem_q[lane_slot[l]] <= rvfi_insn_i[l*ILEN +: ILEN];
        end
      end
    end
  end

`ifdef RVFI_STEP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q;

  // Counts only while a request or result is outstanding; any handshake or result restarts it.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_set   = 1'b0;
    if ((state_q == ISSUE && !step_ready_i) || (state_q == WAIT && !rslt_valid_i)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (tmo_cnt_d == TW'(TIMEOUT)) tmo_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_q | tmo_set;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_set = 1'b0;
`endif

  assign step_valid_o = (state_q == ISSUE);
  assign step_order_o = (state_q == ISSUE) ? ord_mem_q[rd_ptr_q] : '0;
  assign busy_o       = (occ_q != '0) || (state_q != IDLE);
  assign halted_o     = (state_q == HALT);
  assign mismatch_o   = mis_q;
  assign order_err_o  = oerr_q;
  assign overflow_o   = ovf_q;
  assign steps_o      = steps_q;

endmodule

// File: tb/tb_rvfi_step_scheduler.sv
// Directed bench for rvfi_step_scheduler: a vector table for queue/flag corners plus ISS-driven flows.
module tb_rvfi_step_scheduler;
  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NRET-1:0]      rvfi_valid_i;
  logic [NRET*64-1:0]   rvfi_order_i;
  logic [NRET*XLEN-1:0] rvfi_pc_i;
  logic [NRET*ILEN-1:0] rvfi_insn_i;
  logic                 step_valid_o;
  logic                 step_ready_i;
  logic [63:0]          step_order_o;
  logic                 rslt_valid_i;
  logic [XLEN-1:0]      rslt_pc_i;
  logic [ILEN-1:0]      rslt_insn_i;
  logic                 busy_o, halted_o, mismatch_o, order_err_o, overflow_o;
  logic [31:0]          steps_o;

  rvfi_step_scheduler #(.NRET(NRET), .DEPTH(8), .XLEN(XLEN), .ILEN(ILEN), .TIMEOUT(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i),
    .rvfi_pc_i(rvfi_pc_i), .rvfi_insn_i(rvfi_insn_i),
    .step_valid_o(step_valid_o), .step_ready_i(step_ready_i), .step_order_o(step_order_o),
    .rslt_valid_i(rslt_valid_i), .rslt_pc_i(rslt_pc_i), .rslt_insn_i(rslt_insn_i),
    .busy_o(busy_o), .halted_o(halted_o), .mismatch_o(mismatch_o),
    .order_err_o(order_err_o), .overflow_o(overflow_o), .steps_o(steps_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // ISS responder state
  int   iss_cnt, iss_ord, n_rslt, bad_idx;
  logic last_bad;
  int   hs_log[$];

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    int         o0, o1;
    logic       rdy, rv;
    int         ro;
    logic       rbad;
    logic [5:0] ef;   // {step_valid, busy, halted, mismatch, order_err, overflow}
    int         eso;
    int         est;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pc_of(input int o);
    return 32'h8000_0000 + 32'(o) * 32'd4;
  endfunction

  function automatic logic [31:0] insn_of(input int o);
    return 32'h0000_0013 | (32'(o) << 7);
  endfunction

  function automatic vec_t mk(input logic rst, input logic [1:0] vld, input int o0, input int o1,
                              input logic rdy, input logic rv, input int ro, input logic rbad,
                              input logic [5:0] ef, input int eso, input int est);
    vec_t v;
    v.rst = rst; v.vld = vld; v.o0 = o0; v.o1 = o1; v.rdy = rdy; v.rv = rv;
    v.ro = ro; v.rbad = rbad; v.ef = ef; v.eso = eso; v.est = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive_ret(input logic [1:0] v, input int o0, input int o1);
    rvfi_valid_i = v;
    rvfi_order_i = {64'(o1), 64'(o0)};
    rvfi_pc_i    = {pc_of(o1), pc_of(o0)};
    rvfi_insn_i  = {insn_of(o1), insn_of(o0)};
  endtask

  task automatic tick();
    last_bad = 1'b0;
    if (iss_cnt == 1) begin
      rslt_valid_i = 1'b1;
      rslt_pc_i    = pc_of(iss_ord) + ((n_rslt == bad_idx) ? 32'd4 : 32'd0);
      rslt_insn_i  = insn_of(iss_ord);
      last_bad     = (n_rslt == bad_idx);
      n_rslt++;
    end else begin
      rslt_valid_i = 1'b0;
    end
    if (iss_cnt > 0) iss_cnt--;
    if (step_valid_o && step_ready_i) begin
      hs_log.push_back(int'(step_order_o));
      iss_ord = int'(step_order_o);
      iss_cnt = 3;
    end
    @(posedge clk_i);
    #1;
    rvfi_valid_i = '0;
    rslt_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    rvfi_valid_i = '0;
    step_ready_i = 1'b0;
    rslt_valid_i = 1'b0;
    iss_cnt      = 0;
    n_rslt       = 0;
    bad_idx      = -1;
    hs_log.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic any_sv;
    int   n;

    rst_i = 1'b1; rvfi_valid_i = '0; rvfi_order_i = '0; rvfi_pc_i = '0; rvfi_insn_i = '0;
    step_ready_i = 1'b0; rslt_valid_i = 1'b0; rslt_pc_i = '0; rslt_insn_i = '0;
    iss_cnt = 0; iss_ord = 0; n_rslt = 0; bad_idx = -1; last_bad = 1'b0;

    // reset, then overflow with a stalled ISS
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 1, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2, 3, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 4, 5, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 6, 7, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 8, 9, 0, 0, 0, 0, 6'b011001, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 6'b011001, 0, 0));
    vecs.push_back(mk(0, 2'b01, 10, 0, 0, 1, 0, 0, 6'b011001, 0, 0));
    // order gap 0,1,3
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 0, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b01, 3, 0, 0, 0, 0, 0, 6'b011010, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 6'b011010, 0, 0));
    // lane 1 valid without lane 0
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 0, 6'b011010, 0, 0));
    // pop plus 2-lane push at occupancy 7, then fill and overflow
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 1, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2, 3, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 4, 5, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b01, 6, 0, 0, 0, 0, 0, 6'b110000, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0, 0, 0, 6'b010000, 0, 0));
    vecs.push_back(mk(0, 2'b11, 7, 8, 0, 1, 0, 0, 6'b110000, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0, 0, 0, 6'b010000, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1, 1, 0, 6'b110000, 2, 2));
    vecs.push_back(mk(0, 2'b01, 9, 0, 0, 0, 0, 0, 6'b110000, 2, 2));
    vecs.push_back(mk(0, 2'b01, 10, 0, 0, 0, 0, 0, 6'b011001, 0, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_i        = v.rst;
      drive_ret(v.vld, v.o0, v.o1);
      step_ready_i = v.rdy;
      rslt_valid_i = v.rv;
      rslt_pc_i    = pc_of(v.ro) + (v.rbad ? 32'd4 : 32'd0);
      rslt_insn_i  = insn_of(v.ro);
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_flags", i),
          64'({step_valid_o, busy_o, halted_o, mismatch_o, order_err_o, overflow_o}), 64'(v.ef));
      chk($sformatf("vec%0d_steps", i), 64'(steps_o), 64'(v.est));
      if (v.ef[5]) chk($sformatf("vec%0d_order", i), step_order_o, 64'(v.eso));
    end

    // idle for 100 cycles
    do_reset();
    any_sv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      any_sv = any_sv | step_valid_o;
    end
    chk("idle_step_valid", 64'(any_sv), 64'd0);
    chk("idle_outs", 64'({busy_o, halted_o, mismatch_o, order_err_o, overflow_o}), 64'd0);
    chk("idle_steps", 64'(steps_o), 64'd0);

    // five single-lane retires, ISS always ready, results 3 cycles later
    do_reset();
    step_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_ret(2'b01, i, 0);
      tick();
    end
    n = 0;
    while (busy_o && n < 100) begin tick(); n++; end
    chk("flow_drain_busy", 64'(busy_o), 64'd0);
    chk("flow_nhs", 64'(hs_log.size()), 64'd5);
    for (int i = 0; i < hs_log.size(); i++) chk($sformatf("flow_hs%0d", i), 64'(hs_log[i]), 64'(i));
    chk("flow_steps", 64'(steps_o), 64'd5);
    chk("flow_flags", 64'({halted_o, mismatch_o, order_err_o, overflow_o}), 64'd0);

    // two-lane burst with the ISS stalled
    do_reset();
    drive_ret(2'b11, 0, 1);
    tick();
    drive_ret(2'b11, 2, 3);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), 64'(step_valid_o), 64'd1);
      chk($sformatf("stall%0d_order", i), step_order_o, 64'd0);
    end
    step_ready_i = 1'b1;
    n = 0;
    while (busy_o && n < 100) begin tick(); n++; end
    chk("burst_drain_busy", 64'(busy_o), 64'd0);
    chk("burst_nhs", 64'(hs_log.size()), 64'd4);
    for (int i = 0; i < hs_log.size(); i++) chk($sformatf("burst_hs%0d", i), 64'(hs_log[i]), 64'(i));
    chk("burst_steps", 64'(steps_o), 64'd4);
    chk("burst_flags", 64'({halted_o, mismatch_o, order_err_o, overflow_o}), 64'd0);

    // third result carries pc+4
    do_reset();
    bad_idx = 2;
    step_ready_i = 1'b1;
    drive_ret(2'b11, 0, 1);
    tick();
    drive_ret(2'b11, 2, 3);
    tick();
    n = 0;
    while (!halted_o && n < 100) begin tick(); n++; end
    chk("mis_halted", 64'(halted_o), 64'd1);
    chk("mis_same_cycle", 64'(last_bad), 64'd1);
    chk("mis_flag", 64'(mismatch_o), 64'd1);
    chk("mis_steps", 64'(steps_o), 64'd3);
    any_sv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_sv = any_sv | step_valid_o;
    end
    chk("mis_no_step", 64'(any_sv), 64'd0);
    chk("mis_nhs", 64'(hs_log.size()), 64'd3);
    chk("mis_other_flags", 64'({order_err_o, overflow_o}), 64'd0);

    // reset during an offered request
    do_reset();
    drive_ret(2'b01, 0, 0);
    tick();
    step_ready_i = 1'b1;
    chk("rst_pre_valid", 64'(step_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_async_valid", 64'(step_valid_o), 64'd0);
    chk("rst_async_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step_ready_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
